// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / HI-LO interlock and redirect flush control for the pipeline registers.
// Optional stall statistics counter (stall_cnt) is built when HAZARD_STAT_EN is defined.
module hazard_ctrl #(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_uses_hilo,
   input  logic [4:0]  ex_waddr,
   input  logic        ex_is_load,
   input  logic        ex_md_start,
   input  logic        ex_md_is_div,
   input  logic        mem_redirect,
   output logic        pc_wen,
   output logic        if_id_wen,
   output logic        if_id_flush,
   output logic        id_ex_clr,
   output logic        ex_mem_clr,
   output logic        md_busy,
   output logic        md_done
`ifdef HAZARD_STAT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_md_busy;
   logic               r_md_done;

   logic               w_load_use;
   logic               w_md_hold;
   logic               w_md_start;
   logic [CNT_W-1:0]   w_cnt_load;

   // A start squashed by a MEM redirect is wrong-path and never occupies HI/LO.
   assign w_md_start = ex_md_start & ~mem_redirect;
   assign w_cnt_load = ex_md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

   assign w_load_use = ex_is_load & (ex_waddr != 5'd0) &
                       ((id_uses_rs & (id_rs == ex_waddr)) |
                        (id_uses_rt & (id_rt == ex_waddr)));

   assign w_md_hold  = id_uses_hilo & (r_md_busy | w_md_start);

   // Redirect outranks any stall: the stalled instructions are on the wrong path.
   always_comb begin
      pc_wen      = 1'b1;
      if_id_wen   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_clr   = 1'b0;
      ex_mem_clr  = 1'b0;
      if (rst) begin
         if (mem_redirect) begin
            if_id_flush = 1'b1;
            id_ex_clr   = 1'b1;
            ex_mem_clr  = 1'b1;
         end else if (w_load_use | w_md_hold) begin
            pc_wen      = 1'b0;
            if_id_wen   = 1'b0;
            id_ex_clr   = 1'b1;
         end
      end
   end

   // HI/LO occupancy FSM; a redirect while BUSY does not cancel the older op.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_md_busy <= 1'b0;
         r_md_done <= 1'b0;
      end else begin
         r_md_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_md_start) begin
                  r_cnt     <= w_cnt_load;
                  r_state   <= S_BUSY;
                  r_md_busy <= 1'b1;
               end
            end
            S_BUSY: begin
               if (r_cnt <= CNT_W'(1)) begin
                  r_cnt     <= '0;
                  r_state   <= S_DONE;
                  r_md_busy <= 1'b0;
                  r_md_done <= 1'b1;
               end else begin
                  r_cnt     <= r_cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (w_md_start) begin
                  r_cnt     <= w_cnt_load;
                  r_state   <= S_BUSY;
                  r_md_busy <= 1'b1;
               end else begin
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_md_busy <= 1'b0;
            end
         endcase
      end
   end

   assign md_busy = r_md_busy;
   assign md_done = r_md_done;

`ifdef HAZARD_STAT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_cnt <= 32'd0;
      end else if (!pc_wen) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule
